// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data bus request/acknowledge interface of the MEM stage
interface mem_access_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, sel, wdata, input rdata, ack);
   modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: bus transaction, stall, load extension
module mem_access_unit (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [4:0]                 mem_wd,
   input  logic                       mem_wreg,
   input  logic [31:0]                mem_wdata,
   input  logic [5:0]                 mem_aluop,
   input  logic [31:0]                mem_mem_addr,
   input  logic [31:0]                mem_reg2,
   input  logic                       hold,
   mem_access_unit_if.master          dbus,
   output logic                       stallreq,
   output logic [4:0]                 wb_wd,
   output logic                       wb_wreg,
   output logic [31:0]                wb_wdata,
   output logic                       adel,
   output logic                       ades
);
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic        req_q, we_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  sel_q;

   logic        is_load, is_store, is_half, is_word, misaligned, start;
   logic [3:0]  sel_c;
   logic [31:0] wdata_c, load_val;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   assign is_load  = (mem_aluop == OP_LB) || (mem_aluop == OP_LH) || (mem_aluop == OP_LW) ||
                     (mem_aluop == OP_LBU) || (mem_aluop == OP_LHU);
   assign is_store = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
   assign is_half  = (mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH);
   assign is_word  = (mem_aluop == OP_LW) || (mem_aluop == OP_SW);
   assign misaligned = (is_half && mem_mem_addr[0]) || (is_word && (mem_mem_addr[1:0] != 2'b00));
   assign start    = (is_load || is_store) && !misaligned;

   // Big-endian lanes: byte offset 0 lives in sel[3] / data[31:24].
   always_comb begin
      sel_c   = 4'b1111;
      wdata_c = mem_reg2;
      if (is_half) begin
         sel_c   = 4'b1100 >> mem_mem_addr[1:0];
         wdata_c = {2{mem_reg2[15:0]}};
      end else if (!is_word) begin
         sel_c   = 4'b1000 >> mem_mem_addr[1:0];
         wdata_c = {4{mem_reg2[7:0]}};
      end
   end

   always_comb begin
      lane_byte = rdata_q[31:24];
      case (mem_mem_addr[1:0])
         2'd1:    lane_byte = rdata_q[23:16];
         2'd2:    lane_byte = rdata_q[15:8];
         2'd3:    lane_byte = rdata_q[7:0];
         default: lane_byte = rdata_q[31:24];
      endcase
      lane_half = mem_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
      load_val  = rdata_q;
      case (mem_aluop)
         OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
         OP_LBU:  load_val = {24'd0, lane_byte};
         OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
         OP_LHU:  load_val = {16'd0, lane_half};
         default: load_val = rdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         sel_q   <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state   <= BUSY;
               req_q   <= 1'b1;
               we_q    <= is_store;
               addr_q  <= {mem_mem_addr[31:2], 2'b00};
               sel_q   <= sel_c;
               wdata_q <= is_store ? wdata_c : 32'd0;
            end
            BUSY: if (dbus.ack) begin
               state   <= DONE;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
               addr_q  <= 32'd0;
               sel_q   <= 4'd0;
               wdata_q <= 32'd0;
               rdata_q <= dbus.rdata;
            end
            DONE: if (!hold) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign dbus.req   = req_q;
   assign dbus.we    = we_q;
   assign dbus.addr  = addr_q;
   assign dbus.sel   = sel_q;
   assign dbus.wdata = wdata_q;

   // Gated by rst so an asserted reset releases the stall at once, even with a memory op presented.
   assign stallreq = rst && (((state == IDLE) && start) || (state == BUSY));
   assign adel     = rst && is_load && misaligned;
   assign ades     = rst && is_store && misaligned;
   assign wb_wd    = mem_wd;
   assign wb_wreg  = mem_wreg && !misaligned;
   assign wb_wdata = ((state == DONE) && is_load) ? load_val : mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven scoreboard bench for mem_access_unit
module tb_mem_access_unit;
   logic        clk, rst, hold;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata, mem_mem_addr, mem_reg2;
   logic [5:0]  mem_aluop;
   logic        stallreq, wb_wreg, adel, ades;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata;

   mem_access_unit_if dbus();

   mem_access_unit dut (
      .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hold(hold),
      .dbus(dbus), .stallreq(stallreq), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .adel(adel), .ades(ades)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] reg2;
      logic [31:0] rdata;
      int          waits;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] bus_wdata;
      logic [31:0] wb;
   } vec_t;

   typedef struct {
      logic [31:0] wb;
      logic        wreg;
      logic        load;
   } exp_t;

   vec_t vecs[11];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_nop();
      mem_aluop    = 6'h00;
      mem_mem_addr = 32'd0;
      mem_reg2     = 32'd0;
      mem_wreg     = 1'b0;
      mem_wd       = 5'd0;
      mem_wdata    = 32'd0;
      dbus.ack     = 1'b0;
   endtask

   task automatic run_mem(input vec_t v, input int hold_cycles);
      int   stall_cnt = 0;
      int   req_cnt = 0;
      bit   done = 0;
      exp_t e;
      @(posedge clk); #1;
      mem_aluop    = v.op;
      mem_mem_addr = v.addr;
      mem_reg2     = v.reg2;
      mem_wreg     = !v.we;
      mem_wd       = 5'd7;
      mem_wdata    = 32'h0BAD0BAD;
      dbus.rdata   = v.rdata;
      e.wb = v.wb; e.wreg = !v.we; e.load = !v.we;
      sb_q.push_back(e);
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (cyc > 0 && !stallreq) begin
            done = 1;
            break;
         end
         if (stallreq) stall_cnt++;
         if (dbus.req) begin
            req_cnt++;
            chk("bus_addr", dbus.addr, {v.addr[31:2], 2'b00});
            chk("bus_sel", {28'd0, dbus.sel}, {28'd0, v.sel});
            chk("bus_we", {31'd0, dbus.we}, {31'd0, v.we});
            if (v.we) chk("bus_wdata", dbus.wdata, v.bus_wdata);
         end
         dbus.ack = dbus.req && (req_cnt == v.waits + 1);
      end
      e = sb_q.pop_front();
      if (!done) begin
         chk("done_timeout", 32'd0, 32'd1);
      end else begin
         dbus.ack = 1'b0;
         if (e.load) chk("wb_wdata", wb_wdata, e.wb);
         chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, e.wreg});
         chk("done_req", {31'd0, dbus.req}, 32'd0);
         chk("done_sel", {28'd0, dbus.sel}, 32'd0);
         chk("req_cycles", req_cnt, v.waits + 1);
         chk("stall_cycles", stall_cnt, v.waits + 2);
         if (hold_cycles > 0) begin
            hold = 1'b1;
            for (int h = 0; h < hold_cycles; h++) begin
               @(negedge clk);
               chk("hold_wdata", wb_wdata, v.wb);
               chk("hold_req", {31'd0, dbus.req}, 32'd0);
               chk("hold_stall", {31'd0, stallreq}, 32'd0);
            end
            hold = 1'b0;
         end
      end
      set_nop();
   endtask

   initial begin
      vecs[0]  = '{6'h20, 32'h103, 32'h0,        32'h112233F0, 0, 4'b0001, 1'b0, 32'h0,        32'hFFFFFFF0};
      vecs[1]  = '{6'h24, 32'h103, 32'h0,        32'h112233F0, 0, 4'b0001, 1'b0, 32'h0,        32'h000000F0};
      vecs[2]  = '{6'h29, 32'h202, 32'hABCD1234, 32'h0,        3, 4'b0011, 1'b1, 32'h12341234, 32'h0};
      vecs[3]  = '{6'h21, 32'h200, 32'h0,        32'h80017FFF, 1, 4'b1100, 1'b0, 32'h0,        32'hFFFF8001};
      vecs[4]  = '{6'h25, 32'h202, 32'h0,        32'h8001F00D, 0, 4'b0011, 1'b0, 32'h0,        32'h0000F00D};
      vecs[5]  = '{6'h20, 32'h100, 32'h0,        32'h7F000000, 0, 4'b1000, 1'b0, 32'h0,        32'h0000007F};
      vecs[6]  = '{6'h24, 32'h101, 32'h0,        32'h00AB0000, 2, 4'b0100, 1'b0, 32'h0,        32'h000000AB};
      vecs[7]  = '{6'h20, 32'h102, 32'h0,        32'h00008000, 0, 4'b0010, 1'b0, 32'h0,        32'hFFFFFF80};
      vecs[8]  = '{6'h28, 32'h301, 32'h000000A5, 32'h0,        2, 4'b0100, 1'b1, 32'hA5A5A5A5, 32'h0};
      vecs[9]  = '{6'h2B, 32'h304, 32'hCAFEBABE, 32'h0,        0, 4'b1111, 1'b1, 32'hCAFEBABE, 32'h0};
      vecs[10] = '{6'h23, 32'h044, 32'h0,        32'h01234567, 1, 4'b1111, 1'b0, 32'h0,        32'h01234567};

      rst = 1'b0;
      hold = 1'b0;
      dbus.rdata = 32'd0;
      set_nop();
      @(negedge clk);
      chk("rst_req", {31'd0, dbus.req}, 32'd0);
      chk("rst_we", {31'd0, dbus.we}, 32'd0);
      chk("rst_sel", {28'd0, dbus.sel}, 32'd0);
      chk("rst_wdata", dbus.wdata, 32'd0);
      chk("rst_stall", {29'd0, stallreq, adel, ades}, 32'd0);
      rst = 1'b1;

      // Non-memory op passes straight through; a stray ack is ignored in IDLE.
      @(posedge clk); #1;
      mem_aluop = 6'h00; mem_wdata = 32'h1234; mem_wd = 5'd5; mem_wreg = 1'b1; dbus.ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("alu_wdata", wb_wdata, 32'h1234);
         chk("alu_wreg_wd", {26'd0, wb_wreg, wb_wd}, {26'd0, 1'b1, 5'd5});
         chk("alu_req_stall", {30'd0, dbus.req, stallreq}, 32'd0);
      end
      set_nop();

      foreach (vecs[i]) run_mem(vecs[i], 0);

      // Misaligned load and store: flagged, no write, no stall, no request.
      @(posedge clk); #1;
      mem_aluop = 6'h23; mem_mem_addr = 32'h102; mem_wreg = 1'b1;
      @(negedge clk);
      chk("lw_mis_flags", {30'd0, adel, ades}, 32'd2);
      chk("lw_mis_wreg", {31'd0, wb_wreg}, 32'd0);
      chk("lw_mis_stall", {30'd0, stallreq, dbus.req}, 32'd0);
      @(negedge clk);
      chk("lw_mis_req2", {31'd0, dbus.req}, 32'd0);
      mem_aluop = 6'h29; mem_mem_addr = 32'h101; mem_wreg = 1'b0;
      @(negedge clk);
      chk("sh_mis_flags", {30'd0, adel, ades}, 32'd1);
      chk("sh_mis_stall", {30'd0, stallreq, dbus.req}, 32'd0);
      set_nop();

      run_mem('{6'h23, 32'h040, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF}, 2);
      @(negedge clk);
      chk("post_hold_req", {30'd0, dbus.req, stallreq}, 32'd0);

      // Asynchronous reset while BUSY.
      @(posedge clk); #1;
      mem_aluop = 6'h23; mem_mem_addr = 32'h80; mem_wreg = 1'b1; dbus.rdata = 32'h11111111;
      @(negedge clk);
      @(negedge clk);
      chk("busy_req", {31'd0, dbus.req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_busy_req", {31'd0, dbus.req}, 32'd0);
      chk("rst_busy_stall", {31'd0, stallreq}, 32'd0);
      dbus.ack = 1'b1;
      @(negedge clk);
      set_nop();
      rst = 1'b1;
      @(negedge clk);
      chk("after_rst_idle", {30'd0, dbus.req, stallreq}, 32'd0);
      run_mem('{6'h2B, 32'h088, 32'h55AA55AA, 32'h0, 1, 4'b1111, 1'b1, 32'h55AA55AA, 32'h0}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
